// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : MEM pipeline stage controller. Issues data-memory requests,
//            stalls upstream until ack, formats load/store data for MEM/WB.
//            Optional macro MEM_TIMEOUT_EN adds an ACCESS-cycle timeout abort.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ex_ctrl,
    input  logic [15:0] ex_res,
    input  logic [15:0] ex_R15,
    input  logic [15:0] ex_op1,
    input  logic [3:0]  ex_regDes,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  wb_ctrl,
    output logic [15:0] wb_data,
    output logic [15:0] wb_R15,
    output logic [3:0]  wb_regDes,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 15)) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be within 1..15");
    end

    state_t      r_state;
    logic [1:0]  r_hold_wbctrl;
    logic        r_hold_write;
    logic        r_hold_memtoreg;
    logic        r_hold_loadbyte;
    logic [15:0] r_hold_res;
    logic [15:0] r_hold_R15;
    logic [3:0]  r_hold_regdes;

    logic        w_ex_write;
    logic        w_ex_mem;
    logic        w_ex_sbyte;
    logic [7:0]  w_load_byte;
    logic [15:0] w_fmt_data;

    assign w_ex_write = ex_ctrl[4];
    assign w_ex_mem   = ex_ctrl[4] | ex_ctrl[3];
    assign w_ex_sbyte = ex_ctrl[2];

    assign stall = (r_state == S_ACCESS) || ((r_state == S_IDLE) && w_ex_mem);

    // A combined read+write is a store, so the register result is the ALU value.
    always_comb begin
        w_load_byte = r_hold_res[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        w_fmt_data  = r_hold_res;
        if (!r_hold_write && r_hold_memtoreg) begin
            if (r_hold_loadbyte) begin
                w_fmt_data = {{8{w_load_byte[7]}}, w_load_byte};
            end else begin
                w_fmt_data = mem_rdata;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] c_timeout_last = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] r_cnt;
`else
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_be          <= 2'b00;
            mem_addr        <= 15'h0;
            mem_wdata       <= 16'h0000;
            wb_ctrl         <= 2'b00;
            wb_data         <= 16'h0000;
            wb_R15          <= 16'h0000;
            wb_regDes       <= 4'h0;
            r_hold_wbctrl   <= 2'b00;
            r_hold_write    <= 1'b0;
            r_hold_memtoreg <= 1'b0;
            r_hold_loadbyte <= 1'b0;
            r_hold_res      <= 16'h0000;
            r_hold_R15      <= 16'h0000;
            r_hold_regdes   <= 4'h0;
`ifdef MEM_TIMEOUT_EN
            r_cnt           <= 4'h0;
            mem_err         <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            mem_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_ex_mem) begin
                        r_state         <= S_ACCESS;
                        r_hold_wbctrl   <= ex_ctrl[6:5];
                        r_hold_write    <= w_ex_write;
                        r_hold_memtoreg <= ex_ctrl[1];
                        r_hold_loadbyte <= ex_ctrl[0];
                        r_hold_res      <= ex_res;
                        r_hold_R15      <= ex_R15;
                        r_hold_regdes   <= ex_regDes;
                        mem_req         <= 1'b1;
                        mem_we          <= w_ex_write;
                        mem_addr        <= ex_res[15:1];
                        wb_ctrl         <= 2'b00;
                        if (w_ex_write && w_ex_sbyte) begin
                            mem_be    <= ex_res[0] ? 2'b10 : 2'b01;
                            mem_wdata <= {ex_op1[7:0], ex_op1[7:0]};
                        end else begin
                            mem_be    <= 2'b11;
                            mem_wdata <= ex_op1;
                        end
`ifdef MEM_TIMEOUT_EN
                        r_cnt <= 4'h0;
`endif
                    end else begin
                        wb_ctrl   <= ex_ctrl[6:5];
                        wb_data   <= ex_res;
                        wb_R15    <= ex_R15;
                        wb_regDes <= ex_regDes;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        r_state   <= S_DONE;
                        mem_req   <= 1'b0;
                        wb_ctrl   <= r_hold_wbctrl;
                        wb_data   <= w_fmt_data;
                        wb_R15    <= r_hold_R15;
                        wb_regDes <= r_hold_regdes;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == c_timeout_last) begin
                        r_state <= S_DONE;
                        mem_req <= 1'b0;
                        wb_ctrl <= 2'b00;
                        mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'h1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    wb_ctrl <= 2'b00;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  ex_ctrl;
    logic [15:0] ex_res;
    logic [15:0] ex_R15;
    logic [15:0] ex_op1;
    logic [3:0]  ex_regDes;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  wb_ctrl;
    logic [15:0] wb_data;
    logic [15:0] wb_R15;
    logic [3:0]  wb_regDes;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_ctrl   (ex_ctrl),
        .ex_res    (ex_res),
        .ex_R15    (ex_R15),
        .ex_op1    (ex_op1),
        .ex_regDes (ex_regDes),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wb_ctrl   (wb_ctrl),
        .wb_data   (wb_data),
        .wb_R15    (wb_R15),
        .wb_regDes (wb_regDes),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a memory op in IDLE, step into the first ACCESS cycle, then
    // scramble ex_* so that any leakage from the EX side would be visible.
    task automatic start_op(input logic [6:0] c, input logic [15:0] r,
                            input logic [15:0] o, input logic [3:0] d);
        ex_ctrl   = c;
        ex_res    = r;
        ex_op1    = o;
        ex_R15    = 16'hA5A5;
        ex_regDes = d;
        #1;
        check("stall_idle_memop", 32'(stall), 32'h1);
        tick();
        ex_ctrl   = 7'b0000000;
        ex_res    = 16'hFFFF;
        ex_op1    = 16'h0000;
        ex_R15    = 16'h0000;
        ex_regDes = 4'hF;
    endtask

    task automatic ack_op(input logic [15:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; ex_ctrl = '0; ex_res = '0; ex_R15 = '0; ex_op1 = '0;
        ex_regDes = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_wb_ctrl", 32'(wb_ctrl), 32'h0);
        check("rst_wb_data", 32'(wb_data), 32'h0);
        check("rst_wb_regDes", 32'(wb_regDes), 32'h0);
        check("rst_mem_err", 32'(mem_err), 32'h0);
        rst = 1'b0;

        // ALU pass-through
        ex_ctrl = 7'b1000000; ex_res = 16'h1234; ex_R15 = 16'h5555; ex_regDes = 4'd3;
        #1;
        check("alu_stall", 32'(stall), 32'h0);
        tick();
        check("alu_wb_data", 32'(wb_data), 32'h1234);
        check("alu_wb_regDes", 32'(wb_regDes), 32'h3);
        check("alu_wb_ctrl", 32'(wb_ctrl), 32'h2);
        check("alu_wb_R15", 32'(wb_R15), 32'h5555);
        check("alu_stall_after", 32'(stall), 32'h0);

        // ALU op with a stray ack in IDLE
        ex_ctrl = 7'b1100000; ex_res = 16'h7777; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_wb_data", 32'(wb_data), 32'h7777);
        check("stray_ack_wb_ctrl", 32'(wb_ctrl), 32'h3);
        check("stray_ack_mem_req", 32'(mem_req), 32'h0);

        // Word load, ack in third ACCESS cycle
        start_op(7'b1001010, 16'h0040, 16'h0000, 4'd5);
        check("wl_mem_req", 32'(mem_req), 32'h1);
        check("wl_mem_addr", 32'(mem_addr), 32'h0020);
        check("wl_mem_we", 32'(mem_we), 32'h0);
        check("wl_mem_be", 32'(mem_be), 32'h3);
        check("wl_wb_ctrl_access", 32'(wb_ctrl), 32'h0);
        check("wl_stall_a1", 32'(stall), 32'h1);
        tick();
        check("wl_stall_a2", 32'(stall), 32'h1);
        check("wl_addr_held", 32'(mem_addr), 32'h0020);
        tick();
        check("wl_stall_a3", 32'(stall), 32'h1);
        ack_op(16'hBEEF);
        check("wl_wb_data", 32'(wb_data), 32'hBEEF);
        check("wl_wb_regDes", 32'(wb_regDes), 32'h5);
        check("wl_wb_ctrl", 32'(wb_ctrl), 32'h2);
        check("wl_wb_R15", 32'(wb_R15), 32'hA5A5);
        check("wl_mem_req_done", 32'(mem_req), 32'h0);
        check("wl_stall_done", 32'(stall), 32'h0);
        tick();
        check("wl_wb_ctrl_idle", 32'(wb_ctrl), 32'h0);

        // Byte loads, ack in first ACCESS cycle
        start_op(7'b1001011, 16'h0041, 16'h0000, 4'd2);
        check("bl_hi_stall", 32'(stall), 32'h1);
        ack_op(16'h80FF);
        check("bl_hi_wb_data", 32'(wb_data), 32'hFF80);
        check("bl_hi_mem_req", 32'(mem_req), 32'h0);
        tick();
        start_op(7'b1001011, 16'h0040, 16'h0000, 4'd2);
        ack_op(16'h80FF);
        check("bl_lo_wb_data", 32'(wb_data), 32'hFFFF);
        tick();

        // Byte store on odd address
        start_op(7'b0010100, 16'h0011, 16'h12AB, 4'd1);
        check("bs_mem_we", 32'(mem_we), 32'h1);
        check("bs_mem_be", 32'(mem_be), 32'h2);
        check("bs_mem_wdata", 32'(mem_wdata), 32'hABAB);
        check("bs_mem_addr", 32'(mem_addr), 32'h0008);
        check("bs_wb_ctrl_access", 32'(wb_ctrl), 32'h0);
        ack_op(16'h0000);
        check("bs_wb_ctrl_done", 32'(wb_ctrl), 32'h0);
        tick();

        // Word store, address bit 0 ignored
        start_op(7'b0010000, 16'h0011, 16'h12AB, 4'd1);
        check("ws_mem_be", 32'(mem_be), 32'h3);
        check("ws_mem_wdata", 32'(mem_wdata), 32'h12AB);
        ack_op(16'h0000);
        tick();

        // Read and write together: store, wb_data = res
        start_op(7'b1011010, 16'h0022, 16'h3C3C, 4'd7);
        check("rw_mem_we", 32'(mem_we), 32'h1);
        ack_op(16'h5A5A);
        check("rw_wb_data", 32'(wb_data), 32'h0022);
        tick();

        // Read with MemtoReg=0 returns res
        start_op(7'b1001000, 16'h0456, 16'h0000, 4'd4);
        ack_op(16'h9999);
        check("nomtr_wb_data", 32'(wb_data), 32'h0456);
        tick();

        // Reset mid-ACCESS, then a late ack
        start_op(7'b1001010, 16'h0100, 16'h0000, 4'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        #1;
        check("rstmid_mem_req", 32'(mem_req), 32'h0);
        check("rstmid_stall", 32'(stall), 32'h0);
        check("rstmid_wb_ctrl", 32'(wb_ctrl), 32'h0);
        tick();
        mem_ack = 1'b0;
        check("rstmid_mem_req2", 32'(mem_req), 32'h0);
        check("rstmid_wb_ctrl2", 32'(wb_ctrl), 32'h0);

`ifdef MEM_TIMEOUT_EN
        start_op(7'b1001010, 16'h0200, 16'h0000, 4'd8);
        for (int i = 0; i < 7; i++) begin
            check("to_mem_req_held", 32'(mem_req), 32'h1);
            tick();
        end
        check("to_mem_req_last", 32'(mem_req), 32'h1);
        check("to_mem_err_pre", 32'(mem_err), 32'h0);
        tick();
        check("to_mem_req_drop", 32'(mem_req), 32'h0);
        check("to_mem_err", 32'(mem_err), 32'h1);
        check("to_stall_done", 32'(stall), 32'h0);
        check("to_wb_ctrl", 32'(wb_ctrl), 32'h0);
        tick();
        check("to_mem_err_pulse", 32'(mem_err), 32'h0);
        check("to_wb_ctrl_idle", 32'(wb_ctrl), 32'h0);
`else
        start_op(7'b1001010, 16'h0200, 16'h0000, 4'd8);
        repeat (20) tick();
        check("nto_mem_req", 32'(mem_req), 32'h1);
        check("nto_stall", 32'(stall), 32'h1);
        check("nto_mem_err", 32'(mem_err), 32'h0);
        ack_op(16'h4321);
        check("nto_wb_data", 32'(wb_data), 32'h4321);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 8, ACCESS cycles without ack before abort (1..15; used only with MEM_TIMEOUT_EN).
REQ-002 One clock; reset is synchronous and active-high, ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 ex_ctrl  in  7  {regWrite,R15Write,memWrite,memRead,sByte,MemtoReg,loadByte} from EX/MEM register.
REQ-006 ex_res  in  16  ALU result; memory byte address.
REQ-007 ex_R15  in  16  R15 write value.
REQ-008 ex_op1  in  16  store data.
REQ-009 ex_regDes  in  4  destination register.
REQ-010 stall  out  1  freeze upstream pipeline (combinational).
REQ-011 mem_req  out  1  data-memory request, registered.
REQ-012 mem_we  out  1  1 = write.
REQ-013 mem_be  out  2  byte enables; bit0 = low byte (even address).
REQ-014 mem_addr  out  15  word address = res[15:1].
REQ-015 mem_wdata  out  16  write data.
REQ-016 mem_rdata  in  16  read data, valid when mem_ack=1.
REQ-017 mem_ack  in  1  one-cycle completion pulse.
REQ-018 wb_ctrl  out  2  {regWrite,R15Write} to MEM/WB.
REQ-019 wb_data  out  16  register write data.
REQ-020 wb_R15  out  16  R15 write value.
REQ-021 wb_regDes  out  4  destination register.
REQ-022 mem_err  out  1  one-cycle timeout pulse.

Function
REQ-023 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-024 IDLE, memRead=memWrite=0: stall=0; next edge wb_* load ex_* with wb_data=ex_res (1-cycle latency).
REQ-025 IDLE with memRead or memWrite: stall=1 in that cycle; next edge captures all ex_* into holding registers, asserts mem_req, enters ACCESS; wb_ctrl loads 0.
REQ-026 ACCESS: stall=1; mem_req, mem_we, mem_be, mem_addr, mem_wdata held stable until the edge where mem_ack=1 is sampled.
REQ-027 On that edge: FSM enters DONE, mem_req deasserts, wb_* load held values with formatted data.
REQ-028 DONE: stall=0; ex_* ignored; next edge wb_ctrl loads 0 and FSM returns to IDLE.
REQ-029 Minimum memory-op stall is 2 cycles (ack in first ACCESS cycle).
REQ-030 memRead and memWrite both set: treated as write; wb_data=res.
REQ-031 Word store: be=11, wdata=op1, res[0] ignored.
REQ-032 Byte store (sByte): wdata={op1[7:0],op1[7:0]}, be=10 if res[0] else 01.
REQ-033 Word load, MemtoReg=1: wb_data=mem_rdata.
REQ-034 Byte load (loadByte): byte = rdata[15:8] if res[0] else rdata[7:0], sign-extended to 16 bits.
REQ-035 MemtoReg=0: wb_data=held res regardless of read.
REQ-036 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-037 rst=1 at an edge: FSM to IDLE; mem_req, mem_we, mem_be, mem_err, wb_ctrl to 0; mem_addr, mem_wdata, wb_data, wb_R15 to 16'h0000 (addr 15'h0); wb_regDes to 4'h0; timeout counter cleared.
REQ-038 Reset mid-ACCESS SHALL abandon the transaction; an ack arriving afterwards SHALL be ignored.

Configuration
REQ-039 Macro MEM_TIMEOUT_EN defined: a 4-bit counter counts ACCESS cycles; reaching TIMEOUT_CYCLES without ack SHALL deassert mem_req, enter DONE with wb_ctrl=0, and pulse mem_err for one cycle.
REQ-040 MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; mem_err tied 0; no counter logic.

Verification
REQ-041 ALU op, res=16'h1234, regDes=3, regWrite=1 -> next cycle wb_data=16'h1234, wb_regDes=3, stall never 1.
REQ-042 Word load res=16'h0040, ack after 3 ACCESS cycles, rdata=16'hBEEF -> mem_addr=15'h0020, stall high 4 cycles, wb_data=16'hBEEF.
REQ-043 Byte load res=16'h0041, rdata=16'h80FF -> wb_data=16'hFF80; res=16'h0040 -> 16'hFFFF.
REQ-044 Byte store res=16'h0011, op1=16'h12AB -> mem_we=1, be=10, wdata=16'hABAB, wb_ctrl=0.
REQ-045 rst asserted during ACCESS, then ack -> mem_req 0 after edge, FSM IDLE, wb_ctrl stays 0.
REQ-046 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> mem_req drops after 8 ACCESS cycles, mem_err one-cycle pulse, stall released in DONE.
